// File: rtl/p_result_reader.sv
// p_result_reader: consumer end of the DSP48A1 P output path.
// Captures 48-bit P results on a PVALID strobe into a small FIFO. It then
// serialises each word into three 16-bit beats, LSB first, on a valid/ready
// stream. Results that arrive while the FIFO is full are dropped and flagged
// on a sticky OVF. This keeps the DSP pipeline from ever being stalled.
//
// Ports:
//   CLK, RSTN        clock, asynchronous active-low reset
//   P, PVALID        incoming 48-bit result and its one-cycle strobe
//   DOUT, DVALID     current 16-bit beat and its valid
//   DREADY           downstream accepts the beat
//   DLAST            set on beat 2, the last beat of a word
//   COUNT            words held in the FIFO; excludes the word in the serialiser
//   FULL, EMPTY      decoded from the registered COUNT
//   OVF, CLR_OVF     sticky drop flag and its clear
module p_result_reader #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic [47:0]   P,
    input  logic          PVALID,
    output logic [15:0]   DOUT,
    output logic          DVALID,
    input  logic          DREADY,
    output logic          DLAST,
    output logic [CW-1:0] COUNT,
    output logic          FULL,
    output logic          EMPTY,
    output logic          OVF,
    input  logic          CLR_OVF
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PtrOne  = 1;
    localparam logic [CW-1:0] CntOne  = 1;
    localparam logic [CW-1:0] CntFull = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} state_e;

    state_e        state_q, state_d;
    logic [47:0]   mem_q [DEPTH];
    logic [47:0]   hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   dout_q, dout_d;
    logic          dvalid_q, dvalid_d;
    logic          dlast_q, dlast_d;
    logic          ovf_q, ovf_d;

    logic          full, empty, push, drop, pop;
    logic [47:0]   head;

    always_comb begin
        full  = (count_q == CntFull);
        empty = (count_q == '0);
        // FULL is taken from the registered count, so a pop on the same edge
        // does not make room for an incoming word.
        push  = PVALID & ~full;
        drop  = PVALID & full;
        head  = mem_q[rd_ptr_q];

        pop      = 1'b0;
        state_d  = state_q;
        hold_d   = hold_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        dlast_d  = dlast_q;

        // DVALID is high in every B state, so DREADY alone means a handshake.
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop      = 1'b1;
                    hold_d   = head;
                    dout_d   = head[15:0];
                    dvalid_d = 1'b1;
                    dlast_d  = 1'b0;
                    state_d  = StB0;
                end
            end
            StB0: begin
                if (DREADY) begin
                    dout_d  = hold_q[31:16];
                    state_d = StB1;
                end
            end
            StB1: begin
                if (DREADY) begin
                    dout_d  = hold_q[47:32];
                    dlast_d = 1'b1;
                    state_d = StB2;
                end
            end
            StB2: begin
                if (DREADY) begin
                    if (!empty) begin
                        // Reload straight from the FIFO so back-to-back words
                        // stream without an idle cycle.
                        pop     = 1'b1;
                        hold_d  = head;
                        dout_d  = head[15:0];
                        dlast_d = 1'b0;
                        state_d = StB0;
                    end else begin
                        dout_d   = '0;
                        dvalid_d = 1'b0;
                        dlast_d  = 1'b0;
                        state_d  = StIdle;
                    end
                end
            end
            default: begin
                state_d  = StIdle;
                dvalid_d = 1'b0;
                dlast_d  = 1'b0;
                dout_d   = '0;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase

        // A drop on the same edge as a clear leaves the flag set.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= StIdle;
            hold_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dlast_q  <= dlast_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; its contents are meaningless while COUNT is 0.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= P;
        end
    end

    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign DLAST  = dlast_q;
    assign COUNT  = count_q;
    assign FULL   = (count_q == CntFull);
    assign EMPTY  = (count_q == '0);
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_p_result_reader.sv
module tb_p_result_reader;

    logic        CLK;
    logic        RSTN;
    logic [47:0] P;
    logic        PVALID;
    logic [15:0] DOUT;
    logic        DVALID;
    logic        DREADY;
    logic        DLAST;
    logic [2:0]  COUNT;
    logic        FULL;
    logic        EMPTY;
    logic        OVF;
    logic        CLR_OVF;

    int n_checks;
    int n_fail;

    p_result_reader #(
        .DEPTH(4),
        .CW   (3)
    ) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .P      (P),
        .PVALID (PVALID),
        .DOUT   (DOUT),
        .DVALID (DVALID),
        .DREADY (DREADY),
        .DLAST  (DLAST),
        .COUNT  (COUNT),
        .FULL   (FULL),
        .EMPTY  (EMPTY),
        .OVF    (OVF),
        .CLR_OVF(CLR_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [47:0] wrd(input int w);
        return {16'hC000 | 16'(w), 16'hB000 | 16'(w), 16'hA000 | 16'(w)};
    endfunction

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        PVALID  = 1'b0;
        P       = '0;
        DREADY  = 1'b0;
        CLR_OVF = 1'b0;
        RSTN    = 1'b0;
        tick();
        tick();
        RSTN = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        DREADY = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            P = wrd(w);
            PVALID = 1'b1;
            tick();
        end
        PVALID = 1'b0;
        DREADY = 1'b1;
        tick();
        DREADY = 1'b0;
        n_checks++;
        if (DOUT !== 16'hB001 || COUNT !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_setup: DOUT=%h COUNT=%0d, want B001 / 2", DOUT, COUNT);
        end
        #2;
        RSTN = 1'b0;
        #1;
        n_checks++;
        if (DVALID !== 1'b0 || COUNT !== 3'd0 || EMPTY !== 1'b1 || FULL !== 1'b0
            || OVF !== 1'b0 || DOUT !== 16'h0000 || DLAST !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: DVALID=%b COUNT=%0d EMPTY=%b FULL=%b OVF=%b DOUT=%h, want 0/0/1/0/0/0000",
                     DVALID, COUNT, EMPTY, FULL, OVF, DOUT);
        end
        tick();
        RSTN = 1'b1;
        DREADY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (DVALID !== 1'b0 || COUNT !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_residual: cycle %0d DVALID=%b COUNT=%0d, want 0/0", i, DVALID, COUNT);
            end
        end
    endtask

    task automatic test_single_word();
        logic [15:0] exp_b [3];
        exp_b[0] = 16'h89AB;
        exp_b[1] = 16'h4567;
        exp_b[2] = 16'h0123;
        do_reset();
        DREADY = 1'b1;
        P = 48'h0123_4567_89AB;
        PVALID = 1'b1;
        tick();
        PVALID = 1'b0;
        n_checks++;
        if (DVALID !== 1'b0 || COUNT !== 3'd1) begin
            n_fail++;
            $display("FAIL single_latency: DVALID=%b COUNT=%0d, want 0/1", DVALID, COUNT);
        end
        for (int b = 0; b < 3; b++) begin
            tick();
            n_checks++;
            if (DVALID !== 1'b1 || DOUT !== exp_b[b] || DLAST !== (b == 2)) begin
                n_fail++;
                $display("FAIL single_beat%0d: DVALID=%b DOUT=%h DLAST=%b, want 1/%h/%b",
                         b, DVALID, DOUT, DLAST, exp_b[b], (b == 2));
            end
        end
        tick();
        n_checks++;
        if (DVALID !== 1'b0 || EMPTY !== 1'b1) begin
            n_fail++;
            $display("FAIL single_end: DVALID=%b EMPTY=%b, want 0/1", DVALID, EMPTY);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_b [3];
        exp_b[0] = 16'h89AB;
        exp_b[1] = 16'h4567;
        exp_b[2] = 16'h0123;
        do_reset();
        DREADY = 1'b0;
        P = 48'h0123_4567_89AB;
        PVALID = 1'b1;
        tick();
        PVALID = 1'b0;
        tick();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (DVALID !== 1'b1 || DOUT !== exp_b[b] || DLAST !== (b == 2)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d_hold%0d: DVALID=%b DOUT=%h DLAST=%b, want 1/%h/%b",
                             b, i, DVALID, DOUT, DLAST, exp_b[b], (b == 2));
                end
                tick();
            end
            DREADY = 1'b1;
            tick();
            DREADY = 1'b0;
        end
        n_checks++;
        if (DVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: DVALID=%b, want 0", DVALID);
        end
    endtask

    task automatic test_burst_overflow();
        logic [47:0] w;
        do_reset();
        DREADY = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            P = wrd(i);
            PVALID = 1'b1;
            tick();
        end
        PVALID = 1'b0;
        n_checks++;
        if (COUNT !== 3'd4 || FULL !== 1'b1 || OVF !== 1'b1 || EMPTY !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_fill: COUNT=%0d FULL=%b OVF=%b EMPTY=%b, want 4/1/1/0",
                     COUNT, FULL, OVF, EMPTY);
        end
        DREADY = 1'b1;
        for (int j = 0; j < 15; j++) begin
            w = wrd(j / 3 + 1);
            n_checks++;
            if (DVALID !== 1'b1 || DOUT !== w[16*(j%3) +: 16] || DLAST !== ((j % 3) == 2)) begin
                n_fail++;
                $display("FAIL burst_beat%0d: DVALID=%b DOUT=%h DLAST=%b, want 1/%h/%b",
                         j, DVALID, DOUT, DLAST, w[16*(j%3) +: 16], ((j % 3) == 2));
            end
            tick();
        end
        n_checks++;
        if (DVALID !== 1'b0 || EMPTY !== 1'b1) begin
            n_fail++;
            $display("FAIL burst_end: DVALID=%b EMPTY=%b, want 0/1", DVALID, EMPTY);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        DREADY = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            P = wrd(i);
            PVALID = 1'b1;
            tick();
        end
        PVALID = 1'b0;
        DREADY = 1'b1;
        tick();
        tick();
        n_checks++;
        if (COUNT !== 3'd4 || DLAST !== 1'b1 || OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_setup: COUNT=%0d DLAST=%b OVF=%b, want 4/1/1", COUNT, DLAST, OVF);
        end
        // Pop from B2, drop of a new word and OVF clear all on one edge.
        P = wrd(9);
        PVALID = 1'b1;
        CLR_OVF = 1'b1;
        tick();
        PVALID = 1'b0;
        DREADY = 1'b0;
        n_checks++;
        if (COUNT !== 3'd3 || FULL !== 1'b0 || OVF !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_drop_pop: COUNT=%0d FULL=%b OVF=%b, want 3/0/1", COUNT, FULL, OVF);
        end
        n_checks++;
        if (DVALID !== 1'b1 || DOUT !== 16'hA002 || DLAST !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_next_word: DVALID=%b DOUT=%h DLAST=%b, want 1/A002/0", DVALID, DOUT, DLAST);
        end
        tick();
        CLR_OVF = 1'b0;
        n_checks++;
        if (OVF !== 1'b0 || COUNT !== 3'd3) begin
            n_fail++;
            $display("FAIL simul_clr_ovf: OVF=%b COUNT=%0d, want 0/3", OVF, COUNT);
        end
    endtask

    task automatic test_wrap();
        logic [47:0] w;
        int          beat;
        int          sent;
        do_reset();
        DREADY = 1'b1;
        beat = 0;
        sent = 0;
        for (int c = 0; c < 75; c++) begin
            if ((c % 3) == 0 && sent < 20) begin
                P = wrd(sent + 32);
                PVALID = 1'b1;
                sent++;
            end else begin
                PVALID = 1'b0;
            end
            tick();
            n_checks++;
            if (COUNT > 3'd1) begin
                n_fail++;
                $display("FAIL wrap_count: cycle %0d COUNT=%0d, want <=1", c, COUNT);
            end
            if (DVALID === 1'b1) begin
                w = wrd(beat / 3 + 32);
                n_checks++;
                if (beat >= 60 || DOUT !== w[16*(beat%3) +: 16] || DLAST !== ((beat % 3) == 2)) begin
                    n_fail++;
                    $display("FAIL wrap_beat%0d: DOUT=%h DLAST=%b, want %h/%b",
                             beat, DOUT, DLAST, w[16*(beat%3) +: 16], ((beat % 3) == 2));
                end
                beat++;
            end
        end
        PVALID = 1'b0;
        n_checks++;
        if (beat !== 60 || OVF !== 1'b0 || DVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_total: beats=%0d OVF=%b DVALID=%b, want 60/0/0", beat, OVF, DVALID);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RSTN     = 1'b0;
        PVALID   = 1'b0;
        P        = '0;
        DREADY   = 1'b0;
        CLR_OVF  = 1'b0;
        test_reset();
        test_single_word();
        test_backpressure();
        test_burst_overflow();
        test_simultaneous();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/p_result_reader.md
# p_result_reader

Consumer end of the DSP48A1 P output path. Accepts 48-bit P results qualified by a one-cycle valid strobe issued alongside the P register clock enable. Buffers them in a small FIFO and serialises each result into three 16-bit beats on a valid/ready stream for narrow downstream logic. Drop-on-full is reported through a sticky overflow flag, so the DSP pipeline is never back-pressured.

## Interface
Parameters:
- DEPTH, 4, FIFO depth in 48-bit words; power of two, minimum 2.
- CW, 3, width of COUNT; equals log2(DEPTH)+1.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RSTN  input  1  reset; asynchronous, active-low.
- P  input  48  P result word, normally driven from P_mux.
- PVALID  input  1  P holds a new result this cycle.
- DOUT  output  16  current beat.
- DVALID  output  1  DOUT holds a valid beat.
- DREADY  input  1  downstream accepts the beat.
- DLAST  output  1  marks beat 2, the last beat of a word.
- COUNT  output  CW  words held in the FIFO; excludes the word in the serialiser.
- FULL  output  1  COUNT == DEPTH.
- EMPTY  output  1  COUNT == 0.
- OVF  output  1  sticky flag; at least one result was dropped.
- CLR_OVF  input  1  clears OVF.

## Operation
- **Write:** on a rising edge with PVALID=1 and FULL=0, P is stored at the write pointer. The write pointer wraps modulo DEPTH.
- **Dropped write:** PVALID=1 with FULL=1 discards P and sets OVF.
- **Full is evaluated before any same-cycle pop.** A push while full is dropped even if a pop happens on that edge.
- **OVF:** cleared on an edge with CLR_OVF=1 and no drop. If a drop and CLR_OVF occur on the same edge, OVF is set (set wins).
- **Serialiser states:** IDLE, B0, B1, B2.
- **Transitions:**
  - IDLE → B0 when EMPTY=0. The head word is popped into a 48-bit holding register and DOUT=hold[15:0].
  - B0 → B1 on handshake (DVALID & DREADY); DOUT=hold[31:16].
  - B1 → B2 on handshake; DOUT=hold[47:32] and DLAST=1.
  - B2 on handshake: if EMPTY=0, pop the next word and go to B0 in the same edge (no bubble). Otherwise go to IDLE.
- **Outputs by state:**
  - DVALID=1 in B0, B1 and B2; DVALID=0 in IDLE.
  - DOUT and DLAST hold stable while DVALID=1 and DREADY=0.
- **COUNT on a push and pop in the same edge:**
  - Push accepted and pop: COUNT unchanged.
  - Push dropped (FULL) and pop: COUNT decrements.
- FULL and EMPTY are decoded from the registered COUNT.
- Data is never reordered or altered. Beat order is LSB first.
- **Reset (RSTN low, asynchronous):**
  - State returns to IDLE; read and write pointers, COUNT, DOUT, DLAST, DVALID and OVF go to 0.
  - EMPTY=1, FULL=0.
  - FIFO contents are don't-care.
  - A word in flight is lost, with no partial beats after reset release.
- **Reset release:** the first edge with RSTN high may accept a PVALID write.

## Timing
- Write latency: PVALID sampled at edge k gives COUNT+1 after edge k.
- Output latency from an empty, idle reader: the word appears as beat 0 (DVALID=1) after edge k+1. Minimum first-beat latency is 2 edges.
- Throughput: one word every 3 cycles with DREADY held at 1. The FIFO absorbs bursts of up to DEPTH+1 words: DEPTH in the FIFO plus one in the holding register.
- DREADY is sampled only while DVALID=1. DREADY has no combinational path to any output.
- All outputs are registered.

## Test plan
- **Reset values:** assert RSTN=0 mid-operation, with state B1 and COUNT=2. Immediately, without waiting for a clock: DVALID=0, COUNT=0, EMPTY=1, OVF=0, DOUT=0. After release, no residual beats appear.
- **Single word:** P=48'h0123_4567_89AB with one PVALID pulse and DREADY=1. Required: beats 16'h89AB, 16'h4567, 16'h0123 on consecutive cycles; DLAST only on the third beat; first beat 2 edges after the PVALID edge.
- **Back-pressure:** same word with DREADY=0 for 5 cycles on each beat. Each beat holds stable, no beat is skipped and DLAST is correct.
- **Burst and overflow, DEPTH=4:** 7 consecutive PVALID words 1..7 with DREADY=0.
  - Words 1–5 retained, i.e. one popped into the serialiser and four in the FIFO: COUNT=4, FULL=1.
  - Words 6 and 7 dropped; OVF=1.
  - After DREADY=1, output is words 1..5 in order, 15 beats total.
- **Simultaneous events, both with FULL=1:**
  - PVALID arriving on the same edge as a pop: the word is dropped and COUNT goes 4→3.
  - CLR_OVF on the same edge as a drop: OVF stays 1.
  - CLR_OVF alone on the following edge: OVF goes to 0.
- **Wrap-around:** stream 20 words with DREADY=1 and PVALID every 3rd cycle. All 60 beats are correct; pointers wrap several times; COUNT never exceeds 1; OVF=0.
